// File: rtl/axi_lite_param_regbank.sv
// AXI4-Lite slave register bank with byte strobes, read-only status slots,
// per-register access pulses and SLVERR decode for unmapped addresses.
module axi_lite_param_regbank #(
  parameter int                    N_REGS     = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [N_REGS-1:0]     RO_MASK    = 8'hC0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [N_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [N_REGS*DATA_WIDTH-1:0] status_in,
  output logic [N_REGS-1:0]            wr_pulse,
  output logic [N_REGS-1:0]            rd_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  init_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [N_REGS];

  logic                  aw_fire, w_fire, ar_fire, commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [N_REGS-1:0]     aw_sel, ar_sel;
  logic [DATA_WIDTH-1:0] wmask, rd_val;
  logic                  unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[OFFS-1:0], S_AXI_ARADDR[OFFS-1:0]};

  // READY is held low until the first edge after reset releases
  assign S_AXI_AWREADY = init_q && (wr_state_q == WR_IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = init_q && (wr_state_q == WR_IDLE) && !w_held_q;
  assign S_AXI_ARREADY = init_q && (rd_state_q == RD_IDLE);
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = (wr_state_q == WR_IDLE) && aw_held_q && w_held_q;
  assign ar_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:OFFS];

  always_comb begin
    aw_sel = '0;
    ar_sel = '0;
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      aw_sel[i] = (aw_idx_q == IDX_W'(i));
      ar_sel[i] = (ar_idx == IDX_W'(i));
      if (ar_sel[i])
        rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    end
    wmask = '0;
    for (int b = 0; b < STRB_W; b++)
      wmask[b*8 +: 8] = {8{wstrb_q[b]}};
  end

  assign wr_pulse = commit  ? (aw_sel & ~RO_MASK) : '0;
  assign rd_pulse = ar_fire ? ar_sel : '0;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < N_REGS; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
        RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:OFFS];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    unique case (wr_state_q)
      WR_IDLE: if (commit) begin
        wr_state_d = WR_RESP;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        bresp_d    = (|aw_sel) ? 2'b00 : 2'b10;
      end
      WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: if (ar_fire) begin
        rd_state_d = RD_RESP;
        rdata_d    = rd_val;
        rresp_d    = (|ar_sel) ? 2'b00 : 2'b10;
      end
      RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q     <= 1'b0;
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= 2'b00;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      init_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < N_REGS; i++)
        if (wr_pulse[i]) regs_q[i] <= (regs_q[i] & ~wmask) | (wdata_q & wmask);
    end
  end
endmodule

// File: tb/tb_axi_lite_param_regbank.sv
// Randomised and directed bench for axi_lite_param_regbank against a
// byte-level register model (8 regs x 32 bit, regs 6/7 read-only status).
module tb_axi_lite_param_regbank;
  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 6;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic          S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
  logic          S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
  logic          S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [DW-1:0] S_AXI_WDATA = '0, S_AXI_RDATA;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic [NR*DW-1:0] reg_out, status_in = '0;
  logic [NR-1:0] wr_pulse, rd_pulse;

  axi_lite_param_regbank #(.N_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                           .RO_MASK(8'hC0), .RESET_VAL('0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .status_in(status_in),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse));

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_regs [NR];
  int exp_wr_cnt [NR];
  int wr_cnt [NR] = '{default: 0};

  always @(negedge ACLK)
    if (!ARESET)
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) wr_cnt[i]++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Reference model: apply a write, return the expected response
  function automatic logic [1:0] model_write(logic [AW-1:0] addr, logic [31:0] d, logic [3:0] s);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) return 2'b10;
    if (idx >= 6) return 2'b00;
    model_regs[idx] = merge_bytes(model_regs[idx], d, s);
    exp_wr_cnt[idx]++;
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(logic [AW-1:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= NR) return {2'b10, 32'h0};
    if (idx >= 6) return {2'b00, status_in[idx*32 +: 32]};
    return {2'b00, model_regs[idx]};
  endfunction

  task automatic wait_b(output logic [1:0] resp);
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_BVALID && n < 20);
    if (!S_AXI_BVALID) chk("b_timeout", 0, 1);
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge ACLK);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 0;  end
      n++;
    end
    if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_b(resp);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] d,
                         output logic [1:0] resp, output logic [NR-1:0] pulse);
    int n;
    n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
    if (!S_AXI_ARREADY) chk("ar_timeout", 0, 1);
    pulse = rd_pulse;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (!S_AXI_RVALID) chk("r_timeout", 0, 1);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 0;
  endtask

  task automatic write_check(input string tag, input logic [AW-1:0] addr,
                             input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp, eresp;
    int idx;
    do_write(addr, d, s, resp);
    eresp = model_write(addr, d, s);
    chk({tag, "_bresp"}, resp, eresp);
    idx = int'(addr) / 4;
    if (idx < 6) chk({tag, "_reg_out"}, reg_out[idx*32 +: 32], model_regs[idx]);
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] addr);
    logic [31:0] d;
    logic [1:0] resp;
    logic [NR-1:0] pulse, epulse;
    logic [33:0] e;
    int idx;
    e = model_read(addr);
    do_read(addr, d, resp, pulse);
    idx = int'(addr) / 4;
    epulse = (idx < NR) ? NR'(1) << idx : '0;
    chk({tag, "_rdata"}, d, e[31:0]);
    chk({tag, "_rresp"}, resp, e[33:32]);
    chk({tag, "_rd_pulse"}, pulse, epulse);
  endtask

  initial begin
    logic [1:0] resp;
    logic [31:0] d;
    for (int i = 0; i < NR; i++) begin model_regs[i] = '0; exp_wr_cnt[i] = 0; end
    status_in[6*32 +: 32] = 32'hDEAD_0006;
    status_in[7*32 +: 32] = 32'hBEEF_0007;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    chk("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
    chk("rst_reg0", reg_out[31:0], 0);
    chk("rst_pulses", {wr_pulse, rd_pulse}, 0);
    ARESET = 0;
    #1 chk("ready_before_edge", S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    chk("ready_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Fill every slot, then read all back
    for (int i = 0; i < NR; i++) write_check("fill", AW'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < NR; i++) read_check("fill_rd", AW'(i * 4));
    chk("ro_reg_out6", reg_out[6*32 +: 32], 32'hDEAD_0006);

    // Byte strobes
    write_check("full0", 6'h00, 32'h1122_3344, 4'hF);
    write_check("strb0", 6'h00, 32'hAABB_CCDD, 4'b0010);
    chk("strb_model", model_regs[0], 32'h1122_CC44);
    read_check("strb_rd", 6'h00);

    // Out-of-range
    write_check("oor", 6'h20, 32'hFFFF_FFFF, 4'hF);
    read_check("oor_rd", 6'h20);
    read_check("oor_reg0", 6'h00);

    // W three cycles ahead of AW, BREADY held low for five cycles
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    @(negedge ACLK); chk("early_w_ready", S_AXI_WREADY, 1);
    @(posedge ACLK); #1; S_AXI_WVALID = 0;
    repeat (2) @(posedge ACLK);
    #1; S_AXI_AWADDR = 6'h0C; S_AXI_AWVALID = 1;
    @(negedge ACLK); chk("late_aw_ready", S_AXI_AWREADY, 1);
    @(posedge ACLK); #1; S_AXI_AWVALID = 0;
    @(posedge ACLK); #1;
    void'(model_write(6'h0C, 32'h0BAD_F00D, 4'hF));
    S_AXI_AWADDR = 6'h10; S_AXI_AWVALID = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      chk("bvalid_hold", S_AXI_BVALID, 1);
      chk("no_second_aw", S_AXI_AWREADY, 0);
    end
    chk("bresp_hold", S_AXI_BRESP, 2'b00);
    S_AXI_AWVALID = 0; S_AXI_BREADY = 1;
    @(posedge ACLK); #1; S_AXI_BREADY = 0;
    chk("bvalid_drop", S_AXI_BVALID, 0);
    read_check("late_rd3", 6'h0C);
    read_check("late_rd4", 6'h10);

    // Read and write commit to reg 2 in the same cycle
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    @(negedge ACLK); chk("sc_hs", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    @(negedge ACLK);
    chk("sc_same_cycle", {S_AXI_ARREADY, wr_pulse[2]}, 2'b11);
    @(posedge ACLK); #1; S_AXI_ARVALID = 0;
    chk("sc_old_value", S_AXI_RDATA, model_regs[2]);
    @(posedge ACLK); #1; S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    void'(model_write(6'h08, 32'h55, 4'hF));
    read_check("sc_new_value", 6'h08);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) status_in = {$urandom, $urandom, 192'h0};
      if ($urandom_range(0, 1) == 1)
        write_check("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)));
      else
        read_check("rnd_rd", a);
    end

    for (int i = 0; i < NR; i++) chk("wr_pulse_count", wr_cnt[i], exp_wr_cnt[i]);

    // Reset in the middle of a pending read response
    S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(posedge ACLK); #1; S_AXI_ARVALID = 0;
    chk("pre_rst_rvalid", S_AXI_RVALID, 1);
    #2 ARESET = 1;
    #1 chk("rst_drop_rvalid", S_AXI_RVALID, 0);
    chk("rst_drop_ready", {S_AXI_ARREADY, S_AXI_AWREADY}, 0);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    @(posedge ACLK); #1;
    for (int i = 0; i < 6; i++) read_check("post_rst", AW'(i * 4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
